// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 interrupt/exception block:
// register indices, exception codes and Status/Cause bit positions.
package cp0_pkg;

    // CP0 register indices
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // Exception codes written into Cause.ExcCode
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    // Status bit positions
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_IM_LO = 8;

    // Cause bit positions
    localparam int CA_CODE_LO = 2;
    localparam int CA_IP_LO   = 8;
    localparam int IP_TIMER   = 7;

    // Only these synchronous exception codes are accepted; anything else is ignored
    function automatic logic exc_code_valid(input logic [4:0] code);
        return (code == EXC_SYSCALL) || (code == EXC_BREAK) || (code == EXC_TEQ);
    endfunction

endpackage

// File: rtl/cp0_exc_stack.sv
// LIFO of saved {EPC, IE} words for nested exceptions. Entry 0 is the top.
// A push onto a full stack shifts the oldest entry out and keeps the depth.
module cp0_exc_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] entry_reg  [DEPTH];
    logic [WIDTH-1:0] entry_next [DEPTH];
    logic [CW-1:0]    depth_reg;
    logic             pop_en;

    // Push has precedence; popping an empty stack is a no-op
    assign pop_en = pop & ~push & ~empty;
    assign full   = (depth_reg == CW'(DEPTH));
    assign empty  = (depth_reg == '0);
    assign top    = entry_reg[0];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] shift_in;
            logic [WIDTH-1:0] shift_out;
            if (gi == 0) begin : g_first
                assign shift_in = din;
            end else begin : g_inner_in
                assign shift_in = entry_reg[gi-1];
            end
            if (gi == DEPTH - 1) begin : g_last
                assign shift_out = '0;
            end else begin : g_inner_out
                assign shift_out = entry_reg[gi+1];
            end
            assign entry_next[gi] = push   ? shift_in  :
                                    pop_en ? shift_out : entry_reg[gi];
        end
    endgenerate

    // Shift the entries and track occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
            depth_reg <= '0;
        end else begin
            entry_reg <= entry_next;
            if (push && !full) begin
                depth_reg <= depth_reg + 1'b1;
            end else if (pop_en) begin
                depth_reg <= depth_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor-0: Status/Cause/EPC/Count/Compare, maskable external and timer
// interrupts, synchronous exceptions and eret with a nesting stack.
// One event acts per enabled cycle: eret > exception > interrupt > mtc0.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int          N_IRQ       = 6,
    parameter int          STACK_DEPTH = 4,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0004,
    parameter bit          TIMER_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             mfc0,
    input  logic             mtc0,
    input  logic             eret,
    input  logic             exc_req,
    input  logic [4:0]       exc_code,
    input  logic [4:0]       rd,
    input  logic [31:0]      pc,
    input  logic [31:0]      wdata,
    input  logic [N_IRQ-1:0] irq,
    output logic [31:0]      rdata,
    output logic             redirect,
    output logic [31:0]      exc_addr,
    output logic             in_exc
);

    logic [31:0] epc_reg;
    logic        ie_reg;
    logic        ovf_reg;
    logic [7:0]  im_reg;
    logic [4:0]  exc_code_reg;
    logic [31:0] count_reg;
    logic [31:0] count_next;
    logic [31:0] compare_reg;
    logic        timer_ip_reg;

    logic [7:0]  ip;
    logic        exc_valid, irq_pend;
    logic        do_eret, do_exc, do_int, do_mtc0, take;
    logic        compare_wr;
    logic [32:0] stack_top;
    logic        stack_full, stack_empty;
    logic [31:0] status_val, cause_val;

    // Interrupt-pending vector: external lines low, timer on bit 7
    genvar gi;
    generate
        for (gi = 0; gi < IP_TIMER; gi++) begin : g_ip
            if (gi < N_IRQ) begin : g_line
                assign ip[gi] = irq[gi];
            end else begin : g_unused
                assign ip[gi] = 1'b0;
            end
        end
    endgenerate
    assign ip[IP_TIMER] = timer_ip_reg;

    // Event arbitration; losers of a cycle are simply dropped
    assign exc_valid = exc_req & exc_code_valid(exc_code);
    assign irq_pend  = ie_reg & (|(ip & im_reg));
    assign do_eret   = ena & eret;
    assign do_exc    = ena & ~eret & exc_valid;
    assign do_int    = ena & ~eret & ~exc_valid & irq_pend;
    assign do_mtc0   = ena & ~eret & ~exc_valid & ~irq_pend & mtc0;
    assign take      = do_exc | do_int;

    assign redirect  = take | do_eret;
    assign exc_addr  = take ? EXC_VECTOR : (do_eret ? epc_reg : 32'h0);
    assign in_exc    = ~stack_empty;

    cp0_exc_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (33)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (take),
        .pop   (do_eret),
        .din   ({epc_reg, ie_reg}),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Assemble Status and Cause views
    always_comb begin
        status_val                  = '0;
        status_val[ST_IE]           = ie_reg;
        status_val[ST_EXL]          = in_exc;
        status_val[ST_OVF]          = ovf_reg;
        status_val[ST_IM_LO +: 8]   = im_reg;
        cause_val                   = '0;
        cause_val[CA_CODE_LO +: 5]  = exc_code_reg;
        cause_val[CA_IP_LO +: 8]    = ip;
    end

    // mfc0 read mux; always shows the value before this cycle's update
    always_comb begin
        rdata = '0;
        if (mfc0) begin
            case (rd)
                REG_COUNT:   rdata = count_reg;
                REG_COMPARE: rdata = compare_reg;
                REG_STATUS:  rdata = status_val;
                REG_CAUSE:   rdata = cause_val;
                REG_EPC:     rdata = epc_reg;
                default:     rdata = '0;
            endcase
        end
    end

    // Next Count: increment, unless mtc0 Count wins this cycle
    always_comb begin
        count_next = count_reg + 32'd1;
        if (do_mtc0 && (rd == REG_COUNT)) begin
            count_next = wdata;
        end
    end
    assign compare_wr = do_mtc0 && (rd == REG_COMPARE);

    // Count/Compare and the sticky timer interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            compare_reg  <= '0;
            timer_ip_reg <= 1'b0;
        end else if (ena && TIMER_EN) begin
            count_reg <= count_next;
            if (compare_wr) begin
                compare_reg  <= wdata;
                timer_ip_reg <= 1'b0;
            end else if (count_next == compare_reg) begin
                timer_ip_reg <= 1'b1;
            end
        end
    end

    // EPC, IE, OVF, IM and ExcCode updates for the winning event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_reg      <= '0;
            ie_reg       <= 1'b0;
            ovf_reg      <= 1'b0;
            im_reg       <= '0;
            exc_code_reg <= '0;
        end else if (do_eret) begin
            if (!stack_empty) begin
                {epc_reg, ie_reg} <= stack_top;
            end else begin
                ie_reg <= 1'b1;
            end
        end else if (take) begin
            epc_reg      <= pc;
            ie_reg       <= 1'b0;
            exc_code_reg <= do_exc ? exc_code : EXC_INT;
            if (stack_full) begin
                ovf_reg <= 1'b1;
            end
        end else if (do_mtc0) begin
            case (rd)
                REG_STATUS: begin
                    ie_reg  <= wdata[ST_IE];
                    ovf_reg <= wdata[ST_OVF];
                    im_reg  <= wdata[ST_IM_LO +: 8];
                end
                REG_EPC: epc_reg <= wdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: a vector table plus hand-built sequences
// (nesting overflow, timer, same-cycle priority, reset mid-handler).
// Expected outputs are queued when a vector is driven and compared when the
// DUT outputs are sampled on the following falling edge.
module tb_cp0_intc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, mfc0, mtc0, eret, exc_req;
    logic [4:0]  exc_code, rd;
    logic [31:0] pc, wdata;
    logic [5:0]  irq;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] exc_addr;
    logic        in_exc;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        ena, mfc0, mtc0, eret, exc_req;
        logic [4:0]  code, rd;
        logic [31:0] pc, wdata;
        logic [5:0]  irq;
        logic [31:0] e_rdata;
        logic        e_redirect;
        logic [31:0] e_addr;
        logic        e_in_exc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        redirect;
        logic [31:0] addr;
        logic        in_exc;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];

    cp0_intc #(
        .N_IRQ       (6),
        .STACK_DEPTH (4),
        .EXC_VECTOR  (32'h0000_0004),
        .TIMER_EN    (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .mfc0     (mfc0),
        .mtc0     (mtc0),
        .eret     (eret),
        .exc_req  (exc_req),
        .exc_code (exc_code),
        .rd       (rd),
        .pc       (pc),
        .wdata    (wdata),
        .irq      (irq),
        .rdata    (rdata),
        .redirect (redirect),
        .exc_addr (exc_addr),
        .in_exc   (in_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t f_base(input logic inx);
        vec_t v;
        v.ena = 1'b1; v.mfc0 = 1'b0; v.mtc0 = 1'b0; v.eret = 1'b0; v.exc_req = 1'b0;
        v.code = '0; v.rd = '0; v.pc = '0; v.wdata = '0; v.irq = '0;
        v.e_rdata = '0; v.e_redirect = 1'b0; v.e_addr = '0; v.e_in_exc = inx;
        return v;
    endfunction

    function automatic vec_t f_rd(input logic [4:0] r, input logic [31:0] exp, input logic inx);
        vec_t v = f_base(inx);
        v.mfc0 = 1'b1; v.rd = r; v.e_rdata = exp;
        return v;
    endfunction

    function automatic vec_t f_wr(input logic [4:0] r, input logic [31:0] d, input logic inx);
        vec_t v = f_base(inx);
        v.mtc0 = 1'b1; v.rd = r; v.wdata = d;
        return v;
    endfunction

    function automatic vec_t f_exc(input logic [4:0] c, input logic [31:0] p, input logic redir, input logic inx);
        vec_t v = f_base(inx);
        v.exc_req = 1'b1; v.code = c; v.pc = p;
        v.e_redirect = redir; v.e_addr = redir ? 32'h4 : 32'h0;
        return v;
    endfunction

    function automatic vec_t f_irq(input logic [5:0] lines, input logic [31:0] p, input logic redir, input logic inx);
        vec_t v = f_base(inx);
        v.irq = lines; v.pc = p;
        v.e_redirect = redir; v.e_addr = redir ? 32'h4 : 32'h0;
        return v;
    endfunction

    function automatic vec_t f_eret(input logic [31:0] addr, input logic inx);
        vec_t v = f_base(inx);
        v.eret = 1'b1; v.e_redirect = 1'b1; v.e_addr = addr;
        return v;
    endfunction

    task automatic drive_idle(input logic en);
        ena = en; mfc0 = 1'b0; mtc0 = 1'b0; eret = 1'b0; exc_req = 1'b0;
        exc_code = '0; rd = '0; pc = '0; wdata = '0; irq = '0;
    endtask

    // Drive one vector after the rising edge, compare at the falling edge
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        ena = v.ena; mfc0 = v.mfc0; mtc0 = v.mtc0; eret = v.eret; exc_req = v.exc_req;
        exc_code = v.code; rd = v.rd; pc = v.pc; wdata = v.wdata; irq = v.irq;
        sb_q.push_back('{rdata: v.e_rdata, redirect: v.e_redirect, addr: v.e_addr, in_exc: v.e_in_exc});
        @(negedge clk);
        e = sb_q.pop_front();
        $display("txn %s: ena=%b mfc0=%b mtc0=%b eret=%b exc=%b/%0d rd=%0d pc=%h irq=%b -> rdata=%h redirect=%b addr=%h in_exc=%b",
                 tag, ena, mfc0, mtc0, eret, exc_req, exc_code, rd, pc, irq, rdata, redirect, exc_addr, in_exc);
        chk({tag, " rdata"}, rdata, e.rdata);
        chk({tag, " redirect"}, 32'(redirect), 32'(e.redirect));
        chk({tag, " in_exc"}, 32'(in_exc), 32'(e.in_exc));
        if (e.redirect) begin
            chk({tag, " exc_addr"}, exc_addr, e.addr);
        end
    endtask

    // Outputs while reset is held
    task automatic check_in_reset(input string tag);
        mfc0 = 1'b1;
        for (int r = 9; r <= 14; r++) begin
            rd = 5'(r);
            #1;
            chk($sformatf("%s rdata rd%0d", tag, r), rdata, 32'h0);
        end
        chk({tag, " redirect"}, 32'(redirect), 32'h0);
        chk({tag, " in_exc"}, 32'(in_exc), 32'h0);
        mfc0 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        drive_idle(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_in_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- basic table ----------------
        tbl.push_back(f_rd(5'd12, 32'h0, 1'b0));
        tbl.push_back(f_rd(5'd13, 32'h0, 1'b0));
        tbl.push_back(f_rd(5'd14, 32'h0, 1'b0));
        tbl.push_back(f_exc(5'd8, 32'h100, 1'b1, 1'b0));        // syscall taken
        tbl.push_back(f_rd(5'd14, 32'h100, 1'b1));              // EPC
        tbl.push_back(f_rd(5'd13, 32'h20, 1'b1));               // ExcCode 8
        tbl.push_back(f_rd(5'd12, 32'h2, 1'b1));                // IE=0, EXL=1
        tbl.push_back(f_eret(32'h100, 1'b1));
        tbl.push_back(f_rd(5'd14, 32'h0, 1'b0));                // EPC restored
        tbl.push_back(f_exc(5'd5, 32'h300, 1'b0, 1'b0));        // invalid code ignored
        v = f_wr(5'd12, 32'h0000_0101, 1'b0);
        v.mfc0 = 1'b1;                                          // read sees old Status
        tbl.push_back(v);
        tbl.push_back(f_rd(5'd12, 32'h101, 1'b0));
        tbl.push_back(f_irq(6'b000001, 32'h200, 1'b1, 1'b0));   // irq0 taken
        v = f_rd(5'd13, 32'h100, 1'b1);
        v.irq = 6'b000001;                                      // IP0 visible, IE=0 so no take
        tbl.push_back(v);
        tbl.push_back(f_rd(5'd14, 32'h200, 1'b1));
        tbl.push_back(f_rd(5'd12, 32'h102, 1'b1));
        tbl.push_back(f_eret(32'h200, 1'b1));
        tbl.push_back(f_rd(5'd12, 32'h101, 1'b0));              // IE restored to 1
        tbl.push_back(f_wr(5'd12, 32'h0, 1'b0));
        tbl.push_back(f_wr(5'd3, 32'hffff_ffff, 1'b0));         // unmapped write
        tbl.push_back(f_rd(5'd3, 32'h0, 1'b0));
        tbl.push_back(f_wr(5'd13, 32'hffff_ffff, 1'b0));        // Cause is read-only
        tbl.push_back(f_rd(5'd13, 32'h0, 1'b0));
        v = f_exc(5'd9, 32'h333, 1'b0, 1'b0);
        v.ena = 1'b0; v.mfc0 = 1'b1; v.rd = 5'd12;              // frozen, reads still work
        tbl.push_back(v);
        tbl.push_back(f_rd(5'd14, 32'h0, 1'b0));
        tbl.push_back(f_rd(5'd12, 32'h0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // ---------------- nesting beyond the stack depth ----------------
        for (int k = 1; k <= 5; k++) begin
            apply(f_exc(5'd9, 32'(k * 16), 1'b1, k > 1), $sformatf("nest%0d", k));
        end
        apply(f_rd(5'd12, 32'h6, 1'b1), "nest_status");          // EXL + OVF
        // The first-level save (EPC=0) was discarded on overflow, so the four
        // pops restore 0x40,0x30,0x20,0x10 and the depth-0 eret returns 0x10.
        apply(f_eret(32'h50, 1'b1), "eret1");
        apply(f_eret(32'h40, 1'b1), "eret2");
        apply(f_eret(32'h30, 1'b1), "eret3");
        apply(f_eret(32'h20, 1'b1), "eret4");
        apply(f_eret(32'h10, 1'b0), "eret5_empty");
        apply(f_rd(5'd12, 32'h5, 1'b0), "post_nest_status");     // IE set, OVF sticky
        apply(f_wr(5'd12, 32'h0, 1'b0), "clr_status");
        apply(f_rd(5'd12, 32'h0, 1'b0), "status_clr");

        // ---------------- timer ----------------
        apply(f_wr(5'd9, 32'd100, 1'b0), "count_100");
        apply(f_wr(5'd11, 32'd5, 1'b0), "compare_5");
        apply(f_wr(5'd12, 32'h8001, 1'b0), "status_im7");
        apply(f_wr(5'd9, 32'd0, 1'b0), "count_0");
        for (int k = 1; k <= 5; k++) begin
            apply(f_rd(5'd9, 32'(k - 1), 1'b0), $sformatf("tick%0d", k));
        end
        apply(f_irq(6'b0, 32'h400, 1'b1, 1'b0), "timer_take");
        apply(f_rd(5'd13, 32'h8000, 1'b1), "timer_cause");
        apply(f_wr(5'd11, 32'h1000, 1'b1), "compare_clr");
        apply(f_rd(5'd13, 32'h0, 1'b1), "ip7_cleared");
        apply(f_eret(32'h400, 1'b1), "timer_eret");

        // ---------------- same-cycle eret + exception + irq ----------------
        apply(f_wr(5'd12, 32'h0101, 1'b0), "status_im0");
        apply(f_exc(5'd13, 32'h500, 1'b1, 1'b0), "teq");
        v = f_eret(32'h500, 1'b1);
        v.exc_req = 1'b1; v.code = 5'd8; v.irq = 6'b000001; v.pc = 32'h600;
        apply(v, "combo");
        apply(f_rd(5'd13, 32'h34, 1'b0), "combo_cause");          // still TEQ
        apply(f_rd(5'd14, 32'h10, 1'b0), "combo_epc");
        apply(f_irq(6'b000001, 32'h700, 1'b1, 1'b0), "irq_held");
        apply(f_rd(5'd14, 32'h700, 1'b1), "handler_epc");

        // ---------------- async reset mid-handler ----------------
        @(negedge clk);
        drive_idle(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_in_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        apply(f_rd(5'd12, 32'h0, 1'b0), "post_rst_status");
        apply(f_rd(5'd13, 32'h0, 1'b0), "post_rst_cause");
        apply(f_rd(5'd14, 32'h0, 1'b0), "post_rst_epc");
        apply(f_rd(5'd11, 32'h0, 1'b0), "post_rst_compare");
        apply(f_eret(32'h0, 1'b0), "post_rst_eret");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
